// File: rtl/instr_queue.sv
// Instruction queue between fetch/decode and dispatch: a circular FIFO of
// decoded control words and their debug words, with flush and zero-latency head read.

package tomasula_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        regf_we;
  } control_word;
endpackage

package rv32i_types;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_word;
endpackage

module instr_queue
  import tomasula_types::*;
  import rv32i_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_iq,
  input  control_word              control_word_in,
  input  rvfi_word                 rvfi_in,
  output logic                     iq_ack,
  input  logic                     flush_ip,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output control_word              control_word_out,
  output rvfi_word                 rvfi_out,
  output logic                     iq_full,
  output logic                     iq_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  control_word cw_mem_q   [DEPTH];
  rvfi_word    rvfi_mem_q [DEPTH];

  logic enq, deq;

  // Handshakes: enqueue fires when ld_iq and iq_ack are both high; dequeue fires
  // when issue_valid and issue_ready are both high. Each transfers exactly one entry
  // at the next rising edge, and a held request simply retries until it fires.
  assign iq_full     = (count_q == CNT_W'(DEPTH));
  assign iq_empty    = (count_q == '0);
  assign iq_ack      = ld_iq & ~iq_full & ~flush_ip & ~rst;
  assign issue_valid = ~iq_empty & ~flush_ip;

  assign enq = iq_ack;
  assign deq = issue_valid & issue_ready & ~rst;

  // Head is read straight from storage; a freshly written entry appears next cycle.
  assign control_word_out = cw_mem_q[head_q];
  assign rvfi_out         = rvfi_mem_q[head_q];
  assign count            = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_ip) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not architectural, so it is never cleared.
  always_ff @(posedge clk) begin
    if (enq) begin
      cw_mem_q[tail_q]   <= control_word_in;
      rvfi_mem_q[tail_q] <= rvfi_in;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios with random payloads plus a random
// phase, all checked against a queue-based reference model.

module tb_instr_queue;
  import tomasula_types::*;
  import rv32i_types::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    control_word cw;
    rvfi_word    rv;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             ld_iq;
  control_word      control_word_in;
  rvfi_word         rvfi_in;
  logic             iq_ack;
  logic             flush_ip;
  logic             issue_valid;
  logic             issue_ready;
  control_word      control_word_out;
  rvfi_word         rvfi_out;
  logic             iq_full;
  logic             iq_empty;
  logic [CW-1:0]    count;

  entry_t exp_q[$];
  entry_t cur;
  logic   pending;
  int     checks;
  int     errors;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .ld_iq            (ld_iq),
    .control_word_in  (control_word_in),
    .rvfi_in          (rvfi_in),
    .iq_ack           (iq_ack),
    .flush_ip         (flush_ip),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .control_word_out (control_word_out),
    .rvfi_out         (rvfi_out),
    .iq_full          (iq_full),
    .iq_empty         (iq_empty),
    .count            (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic entry_t rand_entry();
    entry_t e;
    e.cw.pc       = $urandom;
    e.cw.opcode   = 7'($urandom);
    e.cw.funct3   = 3'($urandom);
    e.cw.funct7   = 7'($urandom);
    e.cw.rs1      = 5'($urandom);
    e.cw.rs2      = 5'($urandom);
    e.cw.rd       = 5'($urandom);
    e.cw.imm      = $urandom;
    e.cw.regf_we  = 1'($urandom);
    e.rv.valid    = 1'b1;
    e.rv.order    = {$urandom, $urandom};
    e.rv.inst     = $urandom;
    e.rv.rs1_addr = 5'($urandom);
    e.rv.rs2_addr = 5'($urandom);
    e.rv.rd_addr  = 5'($urandom);
    e.rv.pc_rdata = $urandom;
    e.rv.pc_wdata = $urandom;
    return e;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs at negedge against the model, then
  // apply the cycle's effect to the model at the rising edge. The fetch side
  // keeps presenting the same word until it is acked.
  task automatic step(input logic ld, input logic rdy, input logic fl, input logic rs);
    logic exp_ack, exp_valid;
    int   n;
    if (!pending) cur = rand_entry();
    ld_iq           = ld;
    issue_ready     = rdy;
    flush_ip        = fl;
    rst             = rs;
    control_word_in = cur.cw;
    rvfi_in         = cur.rv;
    @(negedge clk);
    n         = exp_q.size();
    exp_ack   = ld && (n < DEPTH) && !fl && !rs;
    exp_valid = (n > 0) && !fl;
    check("iq_ack",      256'(iq_ack),      256'(exp_ack));
    check("issue_valid", 256'(issue_valid), 256'(exp_valid));
    check("count",       256'(count),       256'(n));
    check("iq_full",     256'(iq_full),     256'(n == DEPTH));
    check("iq_empty",    256'(iq_empty),    256'(n == 0));
    if (exp_valid) begin
      check("control_word_out", 256'(control_word_out), 256'(exp_q[0].cw));
      check("rvfi_out",         256'(rvfi_out),         256'(exp_q[0].rv));
    end
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rdy) void'(exp_q.pop_front());
      if (exp_ack) exp_q.push_back(cur);
    end
    pending = ld && !exp_ack && !rs && !fl;
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    pending         = 1'b0;
    cur             = rand_entry();
    rst             = 1'b1;
    ld_iq           = 1'b0;
    flush_ip        = 1'b0;
    issue_ready     = 1'b0;
    control_word_in = cur.cw;
    rvfi_in         = cur.rv;
    repeat (2) @(posedge clk);
    #1;

    // reset state, and ack suppressed while rst is high
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // three consecutive enqueues with dispatch stalled
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

    // fill to DEPTH, hold the extra request, free one slot, then refill
    repeat (DEPTH - 3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // steady state at three entries across pointer wrap
    repeat (DEPTH - 3) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // flush with five entries and both handshakes requested
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // empty queue: no bypass, one cycle to the head
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-operation with an enqueue pending
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
